control_sequencer: RTL and testbench

Hardwired control unit for the bus-based datapath. It is the hardware replacement for the hand-written per-state stimulus previously used to exercise instructions. After fetch it decodes IR[31:27] and drives every datapath strobe through a T0..T7 step sequence, one step per Clock cycle. It sits beside the datapath and drives all of the datapath's control inputs.

---
 rtl/control_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T-step control unit for the bus-based datapath.
// Fetch runs T0..T2, and the opcode is captured on the T2 edge. Execution then
// walks T3..T7 as far as the opcode needs. All strobes are a Moore decode of
// the present state and the captured opcode.
module control_sequencer (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        Rin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  ALUop,
  output logic        Run
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] state_q, state_d;
  logic [4:0] op_q, op_d;

  // Only the opcode field is decoded; the operand fields belong to the datapath.
  logic ir_unused;
  assign ir_unused = ^IR[26:0];

  // Final execution step of each instruction. Unlisted opcodes behave as nop,
  // so they end at T2.
  function automatic logic [3:0] last_step(input logic [4:0] op);
    case (op)
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: last_step = S_T3;
      OP_NEG, OP_NOT:                          last_step = S_T4;
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:        last_step = S_T5;
      OP_MUL, OP_DIV, OP_BR:                   last_step = S_T6;
      OP_LD, OP_ST:                            last_step = S_T7;
      default: begin
        if (op >= OP_ADD && op <= OP_ROL) last_step = S_T5;
        else                              last_step = S_T2;
      end
    endcase
  endfunction

  // ALU code used by the immediate forms (addi/andi/ori map to add/and/or).
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    case (op)
      OP_ANDI: imm_alu = OP_AND;
      OP_ORI:  imm_alu = OP_OR;
      default: imm_alu = OP_ADD;
    endcase
  endfunction

  logic is_alu, is_imm, is_muldiv, is_negnot, is_mem;
  assign is_alu    = (op_q >= OP_ADD) && (op_q <= OP_ROL);
  assign is_imm    = (op_q == OP_ADDI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
  assign is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_negnot = (op_q == OP_NEG) || (op_q == OP_NOT);
  assign is_mem    = (op_q == OP_LD) || (op_q == OP_LDI) || (op_q == OP_ST);

  logic [3:0] end_state;
  assign end_state = Stop ? S_HALT : S_T0;

  // Next-state logic. The opcode is captured on the T2 edge, which is also
  // where nop and halt leave the sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2: begin
        op_d = IR[31:27];
        if (IR[31:27] == OP_HALT)                state_d = S_HALT;
        else if (last_step(IR[31:27]) == S_T2)   state_d = end_state;
        else                                     state_d = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == last_step(op_q)) state_d = end_state;
        else                            state_d = state_q + 4'd1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // State and opcode registers, with a synchronous clear back to Reset.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_RESET;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Moore output decode: every strobe defaults low, and each step raises its own.
  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
    BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0; Rin = 1'b0;
    CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    ALUop = 5'd0;
    Run = (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_muldiv)   begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_negnot)   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op_q; end
        else if (is_mem)      begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else begin
          case (op_q)
            OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        if (is_alu)              begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op_q; end
        else if (is_imm)         begin Cout = 1'b1; Zin = 1'b1; ALUop = imm_alu(op_q); end
        else if (is_muldiv)      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUop = op_q; end
        else if (is_negnot)      begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_mem)         begin Cout = 1'b1; Zin = 1'b1; ALUop = OP_ADD; end
        else if (op_q == OP_BR)  begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        if (is_alu || is_imm || op_q == OP_LDI) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_muldiv)      begin Zlowout = 1'b1; LOin = 1'b1; end
        else if (is_mem)         begin Zlowout = 1'b1; MARin = 1'b1; end
        else if (op_q == OP_BR)  begin Cout = 1'b1; Zin = 1'b1; ALUop = OP_ADD; end
      end
      S_T6: begin
        if (is_muldiv)           begin Zhighout = 1'b1; HIin = 1'b1; end
        else if (op_q == OP_LD)  begin Read = 1'b1; MDRin = 1'b1; end
        else if (op_q == OP_ST)  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (op_q == OP_BR && CON_FF) begin Zlowout = 1'b1; PCin = 1'b1; end
      end
      S_T7: begin
        if (op_q == OP_LD)       begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (op_q == OP_ST)  Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. All outputs are packed into one
// vector and compared each cycle against hand-built expected words.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, Rin, CONin;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] ALUop;

  int n_cmp = 0;
  int n_bad = 0;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .Rin(Rin), .CONin(CONin), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write), .ALUop(ALUop),
    .Run(Run)
  );

  always #5 Clock = ~Clock;

  localparam logic [32:0] PCOUT   = 33'h1 << 32;
  localparam logic [32:0] ZHIGH   = 33'h1 << 31;
  localparam logic [32:0] ZLOW    = 33'h1 << 30;
  localparam logic [32:0] MDROUT  = 33'h1 << 29;
  localparam logic [32:0] HIOUT   = 33'h1 << 28;
  localparam logic [32:0] LOOUT   = 33'h1 << 27;
  localparam logic [32:0] INPOUT  = 33'h1 << 26;
  localparam logic [32:0] COUT    = 33'h1 << 25;
  localparam logic [32:0] BAOUT   = 33'h1 << 24;
  localparam logic [32:0] ROUT    = 33'h1 << 23;
  localparam logic [32:0] MARIN   = 33'h1 << 22;
  localparam logic [32:0] ZIN     = 33'h1 << 21;
  localparam logic [32:0] PCIN    = 33'h1 << 20;
  localparam logic [32:0] MDRIN   = 33'h1 << 19;
  localparam logic [32:0] IRIN    = 33'h1 << 18;
  localparam logic [32:0] YIN     = 33'h1 << 17;
  localparam logic [32:0] HIIN    = 33'h1 << 16;
  localparam logic [32:0] LOIN    = 33'h1 << 15;
  localparam logic [32:0] OUTPIN  = 33'h1 << 14;
  localparam logic [32:0] RIN     = 33'h1 << 13;
  localparam logic [32:0] CONIN   = 33'h1 << 12;
  localparam logic [32:0] GRA     = 33'h1 << 11;
  localparam logic [32:0] GRB     = 33'h1 << 10;
  localparam logic [32:0] GRC     = 33'h1 << 9;
  localparam logic [32:0] INCPC   = 33'h1 << 8;
  localparam logic [32:0] READ    = 33'h1 << 7;
  localparam logic [32:0] WRITE   = 33'h1 << 6;
  localparam logic [32:0] RUN     = 33'h1;

  localparam logic [32:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [32:0] F1 = ZLOW | PCIN | READ | MDRIN | RUN;
  localparam logic [32:0] F2 = MDROUT | IRIN | RUN;

  function automatic logic [32:0] alu(input logic [4:0] code);
    alu = {27'd0, code, 1'b0};
  endfunction

  function automatic logic [32:0] observed();
    observed = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout,
                BAout, Rout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
                OutPortin, Rin, CONin, Gra, Grb, Grc, IncPC, Read, Write, ALUop, Run};
  endfunction

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic step(input string tag, input logic [32:0] exp);
    check(tag, observed(), exp);
    tick();
  endtask

  task automatic fetch(input string tag, input logic [31:0] ir);
    IR = ir;
    step({tag, "_T0"}, F0);
    step({tag, "_T1"}, F1);
    step({tag, "_T2"}, F2);
  endtask

  initial begin
    Clear = 1'b1; IR = 32'h0; CON_FF = 1'b0; Stop = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset", observed(), RUN);
    Clear = 1'b0;
    tick();

    // addi: 6 cycles
    fetch("addi", 32'h6117FFFB);
    step("addi_T3", GRB | ROUT | YIN | RUN);
    step("addi_T4", COUT | ZIN | alu(5'b00011) | RUN);
    step("addi_T5", ZLOW | GRA | RIN | RUN);

    // ld: 8 cycles, Read only in T1 and T6
    fetch("ld", 32'h00000000);
    step("ld_T3", GRB | BAOUT | YIN | RUN);
    step("ld_T4", COUT | ZIN | alu(5'b00011) | RUN);
    step("ld_T5", ZLOW | MARIN | RUN);
    step("ld_T6", READ | MDRIN | RUN);
    step("ld_T7", MDROUT | GRA | RIN | RUN);

    // br taken
    CON_FF = 1'b1;
    fetch("brt", 32'h98000000);
    step("brt_T3", GRA | ROUT | CONIN | RUN);
    step("brt_T4", PCOUT | YIN | RUN);
    step("brt_T5", COUT | ZIN | alu(5'b00011) | RUN);
    step("brt_T6", ZLOW | PCIN | RUN);

    // br not taken
    CON_FF = 1'b0;
    fetch("brn", 32'h98000000);
    step("brn_T3", GRA | ROUT | CONIN | RUN);
    step("brn_T4", PCOUT | YIN | RUN);
    step("brn_T5", COUT | ZIN | alu(5'b00011) | RUN);
    step("brn_T6", RUN);

    // nop and an unassigned opcode: 3 cycles each
    fetch("nop", 32'hD0000000);
    fetch("undef", 32'hF8000000);

    // jr: 4 cycles
    fetch("jr", 32'hA0000000);
    step("jr_T3", GRA | ROUT | PCIN | RUN);

    // neg: 5 cycles
    fetch("neg", 32'h88000000);
    step("neg_T3", GRB | ROUT | ZIN | alu(5'b10001) | RUN);
    step("neg_T4", ZLOW | GRA | RIN | RUN);

    // mul: 7 cycles
    fetch("mul", 32'h78000000);
    step("mul_T3", GRA | ROUT | YIN | RUN);
    step("mul_T4", GRB | ROUT | ZIN | alu(5'b01111) | RUN);
    step("mul_T5", ZLOW | LOIN | RUN);
    step("mul_T6", ZHIGH | HIIN | RUN);

    // add with Stop raised during T4: completes, then Halt
    fetch("add", 32'h18000000);
    step("add_T3", GRB | ROUT | YIN | RUN);
    check("add_T4", observed(), GRC | ROUT | ZIN | alu(5'b00011) | RUN);
    Stop = 1'b1;
    tick();
    step("add_T5", ZLOW | GRA | RIN | RUN);
    for (int i = 0; i < 10; i++) step("stop_halt", 33'h0);
    Stop = 1'b0;
    step("halt_hold", 33'h0);
    Clear = 1'b1;
    tick();
    check("clr_from_halt", observed(), RUN);
    Clear = 1'b0;
    tick();

    // halt opcode: Halt after T2
    fetch("halt", 32'hD8000000);
    step("halt_op0", 33'h0);
    step("halt_op1", 33'h0);
    Clear = 1'b1;
    tick();
    check("clr_halt_op", observed(), RUN);
    Clear = 1'b0;
    tick();

    // st with Clear during T5: no Write, next state Reset
    fetch("st", 32'h10000000);
    step("st_T3", GRB | BAOUT | YIN | RUN);
    step("st_T4", COUT | ZIN | alu(5'b00011) | RUN);
    check("st_T5", observed(), ZLOW | MARIN | RUN);
    Clear = 1'b1;
    tick();
    check("st_clr_reset", observed(), RUN);
    Clear = 1'b0;
    tick();
    step("st_after_T0", F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
